// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter: one register rank per compare-exchange stage, global stall on output backpressure.
// Define BSORT_IDX_EN to carry each element's original input position through the network onto out_idx.
module bitonic_sort_pipe #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_dir,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data
`ifdef BSORT_IDX_EN
  ,
  output logic [N*$clog2(N)-1:0] out_idx
`endif
);
  localparam int L = $clog2(N);
  localparam int S = L * (L + 1) / 2;

  logic         w_adv;
  logic         w_dir_in   [S];
  logic [W-1:0] w_in_data  [S][N];
  logic [W-1:0] w_out_data [S][N];
  logic [W-1:0] r_data     [S][N];
  logic         r_valid    [S];
`ifdef BSORT_IDX_EN
  logic [L-1:0] w_in_tag   [S][N];
  logic [L-1:0] w_out_tag  [S][N];
  logic [L-1:0] r_tag      [S][N];
`endif

  genvar gs, gp, gt, gi;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[S-1];

  for (gs = 0; gs < S; gs++) begin : g_stage_in
    for (gi = 0; gi < N; gi++) begin : g_el
      if (gs == 0) begin : g_first
        assign w_in_data[gs][gi] = in_data[gi*W +: W];
`ifdef BSORT_IDX_EN
        assign w_in_tag[gs][gi] = L'(gi);
`endif
      end else begin : g_rank
        assign w_in_data[gs][gi] = r_data[gs-1][gi];
`ifdef BSORT_IDX_EN
        assign w_in_tag[gs][gi] = r_tag[gs-1][gi];
`endif
      end
    end
  end

  // The last rank's direction feeds nothing, so only S-1 direction registers exist.
  assign w_dir_in[0] = in_dir;
  if (S > 1) begin : g_dir
    logic r_dir [S-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < S - 1; s++) r_dir[s] <= 1'b0;
      end else if (w_adv) begin
        for (int s = 0; s < S - 1; s++) r_dir[s] <= w_dir_in[s];
      end
    end
    for (gs = 1; gs < S; gs++) begin : g_link
      assign w_dir_in[gs] = r_dir[gs-1];
    end
  end

  // Phase gp merges blocks of K = 2^gp; below the final phase, odd blocks sort up and even blocks down.
  for (gp = 1; gp <= L; gp++) begin : g_phase
    for (gt = 0; gt < gp; gt++) begin : g_step
      localparam int SI = gp * (gp - 1) / 2 + gt;
      localparam int K  = 1 << gp;
      localparam int J  = 1 << (gp - 1 - gt);
      for (gi = 0; gi < N; gi++) begin : g_cx
        if ((gi & J) == 0) begin : g_pair
          localparam bit BLK_ASC = (K == N) ? 1'b1 : ((gi & K) != 0);
          logic w_asc;
          logic w_swap;
          assign w_asc  = BLK_ASC ^ w_dir_in[SI];
          assign w_swap = w_asc ? (w_in_data[SI][gi] > w_in_data[SI][gi+J])
                                : (w_in_data[SI][gi] < w_in_data[SI][gi+J]);
          assign w_out_data[SI][gi]   = w_swap ? w_in_data[SI][gi+J] : w_in_data[SI][gi];
          assign w_out_data[SI][gi+J] = w_swap ? w_in_data[SI][gi]   : w_in_data[SI][gi+J];
`ifdef BSORT_IDX_EN
          assign w_out_tag[SI][gi]   = w_swap ? w_in_tag[SI][gi+J] : w_in_tag[SI][gi];
          assign w_out_tag[SI][gi+J] = w_swap ? w_in_tag[SI][gi]   : w_in_tag[SI][gi+J];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < S; s++) begin
        r_valid[s] <= 1'b0;
        for (int i = 0; i < N; i++) r_data[s][i] <= '0;
      end
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < S; s++) r_valid[s] <= r_valid[s-1];
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < N; i++) r_data[s][i] <= w_out_data[s][i];
      end
    end
  end

`ifdef BSORT_IDX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < N; i++) r_tag[s][i] <= '0;
      end
    end else if (w_adv) begin
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < N; i++) r_tag[s][i] <= w_out_tag[s][i];
      end
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_out_idx
    assign out_idx[gi*L +: L] = r_tag[S-1][gi];
  end
`endif

  for (gi = 0; gi < N; gi++) begin : g_out_data
    assign out_data[gi*W +: W] = r_data[S-1][gi];
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe: reset, sort order, interleave, backpressure, edge values, N/W sweep.
// Index checks are compiled in when BSORT_IDX_EN is defined.
module tb_bitonic_sort_pipe;
  localparam int N = 8;
  localparam int W = 8;
  localparam int LG = 3;
  localparam int S = 6;
  localparam logic [63:0] VEC     = 64'hFF01_8003_00FA_0307;  // {7,3,250,0,3,128,1,255}
  localparam logic [63:0] VEC_ASC = 64'hFFFA_8007_0303_0100;  // {0,1,3,3,7,128,250,255}
  localparam logic [63:0] VEC_DSC = 64'h0001_0303_0780_FAFF;  // {255,250,128,7,3,3,1,0}
  localparam logic [23:0] IDX_VEC = 24'o72504163;             // {3,6,1,4,0,5,2,7}
  localparam logic [23:0] IDX_ID  = 24'o76543210;             // {0,1,...,7}

  localparam int SW_N [6] = '{2, 2, 4, 4, 32, 32};
  localparam int SW_W [6] = '{1, 16, 1, 16, 1, 16};
  localparam int SW_S [6] = '{1, 1, 3, 3, 15, 15};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_dir = 1'b0;
  logic out_ready = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic [N*W-1:0] out_data;
`ifdef BSORT_IDX_EN
  logic [N*LG-1:0] out_idx;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitonic_sort_pipe #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BSORT_IDX_EN
    , .out_idx(out_idx)
`endif
  );

  // Sweep instances share one stimulus; each sees the elements truncated to its own width.
  logic [15:0]  sw_elem [32];
  logic         sw_valid = 1'b0;
  logic         sw_dir = 1'b0;
  logic         sw_ov [6];
  logic         sw_ir [6];
  logic [511:0] sw_got [6];

  genvar gc;
  for (gc = 0; gc < 6; gc++) begin : g_sw
    localparam int CN = SW_N[gc];
    localparam int CW = SW_W[gc];
    logic [CN*CW-1:0] din;
    logic [CN*CW-1:0] dout;
    logic [511:0] flat;
    always_comb begin
      din = '0;
      for (int i = 0; i < CN; i++) din[i*CW +: CW] = sw_elem[i][CW-1:0];
    end
    always_comb begin
      flat = '0;
      for (int i = 0; i < CN; i++) flat[i*16 +: 16] = 16'(dout[i*CW +: CW]);
    end
    assign sw_got[gc] = flat;
`ifdef BSORT_IDX_EN
    logic [CN*$clog2(CN)-1:0] didx;
`endif
    bitonic_sort_pipe #(.N(CN), .W(CW)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[gc]), .in_dir(sw_dir),
      .in_data(din), .out_valid(sw_ov[gc]), .out_ready(1'b1), .out_data(dout)
`ifdef BSORT_IDX_EN
      , .out_idx(didx)
`endif
    );
  end

  // Reference: bubble sort of the first n elements masked to w bits, 16 bits per packed slot.
  function automatic logic [511:0] ref_sort(input logic [15:0] a [32], input int n, input int w,
                                            input logic dir);
    logic [15:0] v [32];
    logic [15:0] m;
    logic [15:0] t;
    logic [511:0] r;
    m = 16'((32'd1 << w) - 32'd1);
    for (int i = 0; i < 32; i++) v[i] = a[i] & m;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if (dir ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r[i*16 +: 16] = v[i];
    return r;
  endfunction

  function automatic logic [63:0] ref8(input logic [63:0] d, input logic dir);
    logic [15:0] a [32];
    logic [511:0] r;
    logic [63:0] o;
    for (int i = 0; i < 32; i++) a[i] = (i < 8) ? {8'h00, d[i*8 +: 8]} : 16'h0000;
    r = ref_sort(a, 8, 8, dir);
    for (int i = 0; i < 8; i++) o[i*8 +: 8] = r[i*16 +: 8];
    return o;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Sends one vector into an empty pipeline and waits for its result.
  task automatic run_one(input logic [63:0] d, input logic dir, output int lat,
                         output logic [63:0] got, output logic [23:0] gidx);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = d; in_dir = dir;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = out_data;
`ifdef BSORT_IDX_EN
    gidx = out_idx;
`else
    gidx = '0;
`endif
    $display("[tb] in %h dir %0d -> out %h lat %0d", d, dir, got, lat);
  endtask

  task automatic test_reset();
    int k;
    int seen;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL por_valid: got %b want 0", out_valid); n_bad++; end
    n_vec++; if (out_data !== '0) begin $display("FAIL por_data: got %h want 0", out_data); n_bad++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL por_ready: got %b want 1", in_ready); n_bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = VEC ^ 64'(i); in_dir = 1'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++; if (out_valid !== 1'b1) begin $display("FAIL stall_fill: out_valid %b want 1", out_valid); n_bad++; end
    n_vec++; if (in_ready !== 1'b0) begin $display("FAIL stall_ready: got %b want 0", in_ready); n_bad++; end
    #2 rst_n = 1'b0;
    #1;
    $display("[tb] reset asserted during stall");
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); n_bad++; end
    n_vec++; if (out_data !== '0) begin $display("FAIL rst_data: got %h want 0", out_data); n_bad++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", in_ready); n_bad++; end
`ifdef BSORT_IDX_EN
    n_vec++; if (out_idx !== '0) begin $display("FAIL rst_idx: got %h want 0", out_idx); n_bad++; end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++; if (seen != 0) begin $display("FAIL rst_flush: %0d valid cycles want 0", seen); n_bad++; end
  endtask

  task automatic test_ascending();
    int lat;
    logic [63:0] got;
    logic [23:0] gidx;
    run_one(VEC, 1'b0, lat, got, gidx);
    n_vec++; if (lat != S) begin $display("FAIL asc_latency: got %0d want %0d", lat, S); n_bad++; end
    n_vec++; if (got !== VEC_ASC) begin $display("FAIL asc_data: got %h want %h", got, VEC_ASC); n_bad++; end
`ifdef BSORT_IDX_EN
    n_vec++; if (gidx !== IDX_VEC) begin $display("FAIL asc_idx: got %o want %o", gidx, IDX_VEC); n_bad++; end
`endif
    idle(S);
  endtask

  task automatic test_interleave();
    int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = VEC; in_dir = 1'b0;
    @(negedge clk);
    in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("[tb] interleave first out %h lat %0d", out_data, lat);
    n_vec++; if (lat != S) begin $display("FAIL ilv_latency: got %0d want %0d", lat, S); n_bad++; end
    n_vec++; if (out_data !== VEC_ASC) begin $display("FAIL ilv_asc: got %h want %h", out_data, VEC_ASC); n_bad++; end
    @(negedge clk);
    $display("[tb] interleave second out %h valid %b", out_data, out_valid);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== VEC_DSC) begin
      $display("FAIL ilv_dsc: valid %b data %h want 1 %h", out_valid, out_data, VEC_DSC); n_bad++;
    end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL ilv_tail: valid %b want 0", out_valid); n_bad++; end
    idle(S);
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_q [$];
    logic [63:0] held;
    logic [63:0] want;
    logic stalled;
    int sent;
    int recv;
    int cyc;
    stalled = 1'b0; sent = 0; recv = 0; cyc = 0; held = '0;
    @(negedge clk);
    while (recv < 20 && cyc < 3000) begin
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          $display("FAIL bp_hold: valid %b data %h want 1 %h", out_valid, out_data, held); n_bad++;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            $display("FAIL bp_extra: unexpected out %h", out_data); n_bad++;
          end else begin
            want = exp_q.pop_front();
            if (out_data !== want) begin $display("FAIL bp_data: got %h want %h", out_data, want); n_bad++; end
          end
          $display("[tb] bp recv %0d out %h", recv, out_data);
          recv++;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      if (sent < 20) begin
        in_valid = 1'b1; in_data = {$urandom, $urandom}; in_dir = 1'($urandom_range(0, 1));
        #1;
        if (in_ready) begin
          exp_q.push_back(ref8(in_data, in_dir));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (recv != 20 || sent != 20 || exp_q.size() != 0) begin
      $display("FAIL bp_count: sent %0d recv %0d left %0d want 20 20 0", sent, recv, exp_q.size()); n_bad++;
    end
    idle(S + 2);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain: valid %b want 0", out_valid); n_bad++; end
  endtask

  task automatic test_edge();
    int lat;
    logic [63:0] got;
    logic [23:0] gidx;
    run_one(64'h0, 1'b0, lat, got, gidx);
    n_vec++; if (got !== 64'h0) begin $display("FAIL edge_zero: got %h want 0", got); n_bad++; end
`ifdef BSORT_IDX_EN
    n_vec++; if (gidx !== IDX_ID) begin $display("FAIL edge_zero_idx: got %o want %o", gidx, IDX_ID); n_bad++; end
`endif
    idle(2);
    run_one({8{8'hFF}}, 1'b1, lat, got, gidx);
    n_vec++; if (got !== {8{8'hFF}}) begin $display("FAIL edge_ones: got %h want all ff", got); n_bad++; end
`ifdef BSORT_IDX_EN
    n_vec++; if (gidx !== IDX_ID) begin $display("FAIL edge_ones_idx: got %o want %o", gidx, IDX_ID); n_bad++; end
`endif
    idle(2);
    run_one(64'h0706_0504_0302_0100, 1'b0, lat, got, gidx);
    n_vec++;
    if (got !== 64'h0706_0504_0302_0100 || lat != S) begin
      $display("FAIL edge_sorted: got %h lat %0d want 0706050403020100 %0d", got, lat, S); n_bad++;
    end
    idle(2);
    run_one(64'h0706_0504_0302_0100, 1'b1, lat, got, gidx);
    n_vec++;
    if (got !== 64'h0001_0203_0405_0607) begin
      $display("FAIL edge_sorted_dsc: got %h want 0001020304050607", got); n_bad++;
    end
    idle(2);
  endtask

  task automatic test_sweep();
    int lat [6];
    logic [511:0] got [6];
    logic [511:0] want;
    bit seen [6];
    int cyc;
    bit all_seen;
    for (int c = 0; c < 6; c++) begin
      n_vec++; if (sw_ir[c] !== 1'b1) begin $display("FAIL sw_ready cfg %0d: got %b want 1", c, sw_ir[c]); n_bad++; end
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      for (int i = 0; i < 32; i++)
        sw_elem[i] = (t == 2) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      sw_dir = (t == 0) ? 1'b0 : (t == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin seen[c] = 1'b0; lat[c] = 0; got[c] = '0; end
      cyc = 1;
      all_seen = 1'b0;
      while (!all_seen && cyc < 40) begin
        all_seen = 1'b1;
        for (int c = 0; c < 6; c++) begin
          if (!seen[c] && sw_ov[c]) begin seen[c] = 1'b1; lat[c] = cyc; got[c] = sw_got[c]; end
          if (!seen[c]) all_seen = 1'b0;
        end
        if (!all_seen) begin
          @(negedge clk);
          cyc++;
        end
      end
      for (int c = 0; c < 6; c++) begin
        want = ref_sort(sw_elem, SW_N[c], SW_W[c], sw_dir);
        $display("[tb] sweep t%0d N=%0d W=%0d dir %0d lat %0d", t, SW_N[c], SW_W[c], sw_dir, lat[c]);
        n_vec++;
        if (lat[c] != SW_S[c]) begin
          $display("FAIL sw_latency N=%0d W=%0d: got %0d want %0d", SW_N[c], SW_W[c], lat[c], SW_S[c]); n_bad++;
        end
        n_vec++;
        if (got[c] !== want) begin
          $display("FAIL sw_data N=%0d W=%0d: got %h want %h", SW_N[c], SW_W[c], got[c][127:0], want[127:0]);
          n_bad++;
        end
      end
      idle(2);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sw_elem[i] = 16'h0000;
    test_reset();
    test_ascending();
    test_interleave();
    test_backpressure();
    test_edge();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
